// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: default widths, atan table, FSM encoding and 1/K shift set.
// The 1/K shift set is only used by builds with CORDIC_GAIN_COMP_EN defined.
package cordic_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int N_ITER_DEF = 7;
    localparam int GUARD_DEF  = 2;

    // 1/K ~ 0.6074 ~ 2^-1 + 2^-3 - 2^-6 - 2^-9
    localparam int                INVK_N            = 4;
    localparam int                INVK_SH [INVK_N]  = '{1, 3, 6, 9};
    localparam logic [INVK_N-1:0] INVK_NEG          = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } cordic_state_e;

    // round(atan(2^-i) * 2^7 / pi), binary-angle units for an 8-bit angle
    function automatic int atan_lut(input int i);
        case (i)
            0:       return 32;
            1:       return 19;
            2:       return 10;
            3:       return 5;
            4:       return 3;
            5:       return 1;
            6:       return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_micro_rotation.sv
// One combinational CORDIC micro-rotation: x/y shift-add plus angle accumulate.
// Shared between the vectoring and rotation cores.
module cordic_micro_rotation #(
    parameter int XW = 10,
    parameter int ZW = 8,
    parameter int CW = 3
) (
    input  logic signed [XW-1:0] i_x,
    input  logic signed [XW-1:0] i_y,
    input  logic signed [ZW-1:0] i_z,
    input  logic signed [ZW-1:0] i_atan,
    input  logic        [CW-1:0] i_shift,
    input  logic                 i_dir_pos,
    output logic signed [XW-1:0] o_x,
    output logic signed [XW-1:0] o_y,
    output logic signed [ZW-1:0] o_z
);

    logic signed [XW-1:0] w_x_sh;
    logic signed [XW-1:0] w_y_sh;

    assign w_x_sh = i_x >>> i_shift;
    assign w_y_sh = i_y >>> i_shift;

    // Positive direction drives y toward zero from above
    always_comb begin
        if (i_dir_pos) begin
            o_x = i_x + w_y_sh;
            o_y = i_y - w_x_sh;
            o_z = i_z + i_atan;
        end else begin
            o_x = i_x - w_y_sh;
            o_y = i_y + w_x_sh;
            o_z = i_z - i_atan;
        end
    end

endmodule

// File: rtl/cordic_vectoring_iterative.sv
// Iterative vectoring CORDIC: (x,y) -> magnitude and phase, one micro-rotation per clock.
// Optional CORDIC_GAIN_COMP_EN adds a SCALE state so mag_o is the true magnitude.
module cordic_vectoring_iterative
    import cordic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_ITER = N_ITER_DEF,
    parameter int GUARD  = GUARD_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] y_i,
    input  logic                     data_in_valid_strobe_i,
    output logic        [DATA_W:0]   mag_o,
    output logic signed [DATA_W-1:0] angle_o,
    output logic                     data_out_valid_strobe_o,
    output logic                     busy_o
);

    localparam int XW = DATA_W + GUARD;
    localparam int MW = DATA_W + 1;
    localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    cordic_state_e r_state;
    cordic_state_e w_state_nxt;

    logic signed [XW-1:0]     r_x;
    logic signed [XW-1:0]     r_y;
    logic signed [DATA_W-1:0] r_z;
    logic        [CW-1:0]     r_cnt;
    logic                     r_zero;
    logic        [MW-1:0]     r_mag;
    logic signed [DATA_W-1:0] r_angle;

    logic signed [XW-1:0]     w_x_ext;
    logic signed [XW-1:0]     w_y_ext;
    logic signed [XW-1:0]     w_x_init;
    logic signed [XW-1:0]     w_y_init;
    logic signed [DATA_W-1:0] w_z_init;
    logic                     w_neg;
    logic signed [XW-1:0]     w_x_rot;
    logic signed [XW-1:0]     w_y_rot;
    logic signed [DATA_W-1:0] w_z_rot;
    logic signed [DATA_W-1:0] w_atan;
    logic                     w_dir_pos;
    logic                     w_last;
    logic                     w_start;

    function automatic logic [MW-1:0] sat_mag(input logic signed [XW-1:0] v);
        if (v < 0) return '0;
        if (int'(v) > (2 ** MW) - 1) return '1;
        return MW'(v);
    endfunction

    // Left-half-plane inputs are folded by pi; negation in guarded width cannot overflow
    assign w_neg    = x_i[DATA_W-1];
    assign w_x_ext  = {{GUARD{x_i[DATA_W-1]}}, x_i};
    assign w_y_ext  = {{GUARD{y_i[DATA_W-1]}}, y_i};
    assign w_x_init = w_neg ? -w_x_ext : w_x_ext;
    assign w_y_init = w_neg ? -w_y_ext : w_y_ext;
    assign w_z_init = w_neg ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    assign w_start   = (r_state == ST_IDLE) && data_in_valid_strobe_i;
    assign w_last    = (r_cnt == CW'(N_ITER - 1));
    assign w_dir_pos = ~r_y[XW-1];
    assign w_atan    = DATA_W'(atan_lut(int'(r_cnt)));

    cordic_micro_rotation #(
        .XW (XW),
        .ZW (DATA_W),
        .CW (CW)
    ) u_rot (
        .i_x       (r_x),
        .i_y       (r_y),
        .i_z       (r_z),
        .i_atan    (w_atan),
        .i_shift   (r_cnt),
        .i_dir_pos (w_dir_pos),
        .o_x       (w_x_rot),
        .o_y       (w_y_rot),
        .o_z       (w_z_rot)
    );

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [XW-1:0] w_x_scaled;

    always_comb begin
        w_x_scaled = '0;
        for (int k = 0; k < INVK_N; k++) begin
            if (INVK_NEG[k]) w_x_scaled = w_x_scaled - (r_x >>> INVK_SH[k]);
            else             w_x_scaled = w_x_scaled + (r_x >>> INVK_SH[k]);
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (data_in_valid_strobe_i) w_state_nxt = ST_ITER;
            end
            ST_ITER: begin
`ifdef CORDIC_GAIN_COMP_EN
                if (w_last) w_state_nxt = ST_SCALE;
`else
                if (w_last) w_state_nxt = ST_DONE;
`endif
            end
            ST_SCALE: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_mag   <= '0;
            r_angle <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_x    <= w_x_init;
                        r_y    <= w_y_init;
                        r_z    <= w_z_init;
                        r_cnt  <= '0;
                        r_zero <= (x_i == '0) && (y_i == '0);
                    end
                end
                ST_ITER: begin
                    r_x   <= w_x_rot;
                    r_y   <= w_y_rot;
                    r_z   <= w_z_rot;
                    r_cnt <= r_cnt + CW'(1);
`ifndef CORDIC_GAIN_COMP_EN
                    // Result registers load on the final rotation so DONE presents them
                    if (w_last) begin
                        r_mag   <= r_zero ? '0 : sat_mag(w_x_rot);
                        r_angle <= r_zero ? '0 : w_z_rot;
                    end
`endif
                end
                ST_SCALE: begin
`ifdef CORDIC_GAIN_COMP_EN
                    r_mag   <= r_zero ? '0 : sat_mag(w_x_scaled);
                    r_angle <= r_zero ? '0 : r_z;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign mag_o                   = r_mag;
    assign angle_o                 = r_angle;
    assign data_out_valid_strobe_o = (r_state == ST_DONE);
    assign busy_o                  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
// Scoreboard bench for cordic_vectoring_iterative (DATA_W=8, N_ITER=7, GUARD=2).
// Expected magnitude/phase come from a floating-point reference with LSB tolerances.
module tb_cordic_vectoring_iterative;

    localparam int DW = 8;
    localparam int NI = 7;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = NI + 2;
`else
    localparam int LAT = NI + 1;
`endif

    typedef struct {
        int mag;
        int ang;
        int mtol;
        int t0;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] x_in;
    logic signed [DW-1:0] y_in;
    logic                 stb_in;
    logic        [DW:0]   mag;
    logic signed [DW-1:0] angle;
    logic                 stb_out;
    logic                 busy;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   nstrobe = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_vectoring_iterative #(
        .DATA_W (DW),
        .N_ITER (NI),
        .GUARD  (2)
    ) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .x_i                     (x_in),
        .y_i                     (y_in),
        .data_in_valid_strobe_i  (stb_in),
        .mag_o                   (mag),
        .angle_o                 (angle),
        .data_out_valid_strobe_o (stb_out),
        .busy_o                  (busy)
    );

    task automatic chk(input string tag, input int got, input int exp,
                       input int tol, input int modw);
        int d;
        checks++;
        d = got - exp;
        if (modw > 0) begin
            d = ((d % modw) + modw) % modw;
            if (d > modw / 2) d -= modw;
        end
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input int mtol);
        real  pi;
        real  k;
        real  p;
        real  m;
        exp_t e;
        pi = 3.14159265358979;
        k  = 1.0;
        p  = 1.0;
        for (int i = 0; i < NI; i++) begin
            k = k * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        if (x == 0 && y == 0) begin
            e.mag = 0;
            e.ang = 0;
        end else begin
            m = $sqrt(real'(x * x + y * y));
`ifndef CORDIC_GAIN_COMP_EN
            m = m * k;
`endif
            e.mag = int'(m);
            e.ang = int'($atan2(real'(y), real'(x)) * 128.0 / pi);
        end
        e.mtol = mtol;
        e.t0   = 0;
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (stb_out) begin
            nstrobe++;
            chk("sb_pending", int'(sb.size() > 0), 1, 0, 0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("mag", int'(mag), e.mag, e.mtol, 0);
                chk("angle", int'(angle), e.ang, 1, 256);
                chk("latency", cyc - e.t0 + 1, LAT, 0, 0);
            end
        end
    end

    task automatic drive(input int x, input int y, input bit push, input int mtol);
        exp_t e;
        @(negedge clk);
        x_in   = DW'(x);
        y_in   = DW'(y);
        stb_in = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e    = model(x, y, mtol);
            e.t0 = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        stb_in = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("timeout", n, 0, 59, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        rst    = 1'b1;
        x_in   = '0;
        y_in   = '0;
        stb_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_mag", int'(mag), 0, 0, 0);
        chk("rst_angle", int'(angle), 0, 0, 0);
        chk("rst_stb", int'(stb_out), 0, 0, 0);
        chk("rst_busy", int'(busy), 0, 0, 0);

        drive(64, 0, 1, 2);
        wait_done();
        drive(0, 64, 1, 2);
        wait_done();
        drive(0, -64, 1, 2);
        wait_done();
        drive(-64, 0, 1, 2);
        wait_done();
        // Truncation error accumulates most on the diagonal
        drive(45, 45, 1, 4);
        wait_done();
        drive(-128, -128, 1, 4);
        wait_done();

        n0 = nstrobe;
        drive(0, 0, 1, 0);
        wait_done();
        chk("zero_one_stb", nstrobe - n0, 1, 0, 0);

        n0 = nstrobe;
        drive(64, 0, 1, 2);
        repeat (2) @(negedge clk);
        chk("busy_mid", int'(busy), 1, 0, 0);
        drive(-64, 0, 0, 0);
        wait_done();
        chk("ignored_one_stb", nstrobe - n0, 1, 0, 0);

        drive(64, 0, 1, 2);
        n = 0;
        while (!stb_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", n, 0, 19, 0);
        x_in   = 8'sd0;
        y_in   = 8'sd64;
        stb_in = 1'b1;
        @(negedge clk);
        stb_in = 1'b0;
        chk("busy_after_done", int'(busy), 0, 0, 0);

        drive(0, 64, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0, 0, 0);
        chk("abort_mag", int'(mag), 0, 0, 0);
        chk("abort_angle", int'(angle), 0, 0, 0);
        n0 = nstrobe;
        repeat (12) @(negedge clk);
        chk("abort_no_stb", nstrobe - n0, 0, 0, 0);
        drive(0, -64, 1, 2);
        wait_done();

        chk("sb_empty", sb.size(), 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
